stream_fifo: RTL and testbench

Parametrised synchronous stream FIFO for the pixel-clock domain with full valid/ready flow control on both sides. It buffers DATA_WIDTH-bit beats plus a per-beat last flag, and presents first-word-fall-through output. It reports fill level, almost-full and the number of complete packets stored, so downstream blocks can start a frame or row only once a whole packet is buffered. It replaces the always-valid/always-ready buffer between the pixel producer and consumer.

---
 rtl/stream_fifo.sv | 131 +++++++++++++
 tb/tb_stream_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous valid/ready stream FIFO with first-word-fall-through
// output, fill level, almost-full and a count of complete packets in storage.
//
// Ports:
//   clk_pixel             sole clock, rising edge
//   rst_in                synchronous active-high reset
//   sender_valid_in       sender beat valid
//   sender_last_in        beat closes a packet
//   sender_data_in        beat payload
//   fifo_ready_out        FIFO accepts a beat this cycle
//   receiver_ready_in     receiver takes the presented beat
//   receiver_valid_out    head beat is valid
//   receiver_data_out     head payload (combinational from storage)
//   receiver_last_out     head last flag (combinational from storage)
//   fill_count_out        beats stored (registered)
//   almost_full_out       fill >= ALMOST_FULL_THRESH (registered)
//   packet_count_out      last flags in storage (registered)
//   packet_available_out  packet_count_out != 0 (registered)
module stream_fifo #(
    parameter int unsigned DEPTH              = 144,
    parameter int unsigned DATA_WIDTH         = 256,
    parameter int unsigned ALMOST_FULL_THRESH = DEPTH - 8
) (
    input  logic                         clk_pixel,
    input  logic                         rst_in,
    input  logic                         sender_valid_in,
    input  logic                         sender_last_in,
    input  logic [DATA_WIDTH-1:0]        sender_data_in,
    output logic                         fifo_ready_out,
    input  logic                         receiver_ready_in,
    output logic                         receiver_valid_out,
    output logic [DATA_WIDTH-1:0]        receiver_data_out,
    output logic                         receiver_last_out,
    output logic [$clog2(DEPTH+1)-1:0]   fill_count_out,
    output logic                         almost_full_out,
    output logic [$clog2(DEPTH+1)-1:0]   packet_count_out,
    output logic                         packet_available_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(ALMOST_FULL_THRESH);

    // Each entry holds {last, data}; contents are never reset.
    logic [DATA_WIDTH:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] pkt_q;
    logic [CNT_W-1:0] pkt_nxt;
    logic             valid_q;
    logic             af_q;
    logic             pkt_avail_q;
    logic             wr_fire;
    logic             rd_fire;
    logic [DATA_WIDTH:0] head;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready comes only from the registered count, never from the read side.
    assign fifo_ready_out     = !rst_in && (count_q < CNT_FULL);
    assign receiver_valid_out = valid_q;
    assign wr_fire            = sender_valid_in && fifo_ready_out;
    assign rd_fire            = valid_q && receiver_ready_in;

    // First-word-fall-through head.
    assign head              = mem[rd_ptr];
    assign receiver_data_out = head[DATA_WIDTH-1:0];
    assign receiver_last_out = head[DATA_WIDTH];

    assign fill_count_out       = count_q;
    assign packet_count_out     = pkt_q;
    assign almost_full_out      = af_q;
    assign packet_available_out = pkt_avail_q;

    // Next fill level and packet count; simultaneous fires cancel.
    always_comb begin
        count_nxt = count_q;
        pkt_nxt   = pkt_q;
        if (wr_fire && !rd_fire) begin
            count_nxt = count_q + CNT_W'(1);
        end else if (!wr_fire && rd_fire) begin
            count_nxt = count_q - CNT_W'(1);
        end
        if ((wr_fire && sender_last_in) && !(rd_fire && receiver_last_out)) begin
            pkt_nxt = pkt_q + CNT_W'(1);
        end else if (!(wr_fire && sender_last_in) && (rd_fire && receiver_last_out)) begin
            pkt_nxt = pkt_q - CNT_W'(1);
        end
    end

    // Storage write; wr_fire is already gated off during reset.
    always_ff @(posedge clk_pixel) begin
        if (wr_fire) begin
            mem[wr_ptr] <= {sender_last_in, sender_data_in};
        end
    end

    // Pointers, counts and registered status flags.
    always_ff @(posedge clk_pixel) begin
        if (rst_in) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            pkt_q       <= '0;
            valid_q     <= 1'b0;
            af_q        <= 1'b0;
            pkt_avail_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_fire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count_q     <= count_nxt;
            pkt_q       <= pkt_nxt;
            valid_q     <= (count_nxt != '0);
            af_q        <= (count_nxt >= CNT_AF);
            pkt_avail_q <= (pkt_nxt != '0);
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: a DEPTH=144 instance exercised by a
// vector table and hand-written sequences against a scoreboard model, and a
// DEPTH=5 instance streamed continuously to exercise pointer wrap.
module tb_stream_fifo;

    localparam int A_DEPTH = 144;
    localparam int A_AF    = A_DEPTH - 8;
    localparam int B_DEPTH = 5;

    logic clk;
    logic rst;

    logic        a_sv, a_sl, a_rr;
    logic [15:0] a_sd;
    logic        a_ready, a_valid, a_last, a_af, a_pav;
    logic [15:0] a_data;
    logic [7:0]  a_fill, a_pkt;

    logic        b_sv, b_sl, b_rr;
    logic [15:0] b_sd;
    logic        b_ready, b_valid, b_last, b_af, b_pav;
    logic [15:0] b_data;
    logic [2:0]  b_fill, b_pkt;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard model of instance A.
    logic [16:0] sb[$];
    int          m_cnt = 0;
    int          m_pkt = 0;
    int          n_pops = 0;
    logic [15:0] last_rd = '0;

    stream_fifo #(.DEPTH(A_DEPTH), .DATA_WIDTH(16)) dut_a (
        .clk_pixel            (clk),
        .rst_in               (rst),
        .sender_valid_in      (a_sv),
        .sender_last_in       (a_sl),
        .sender_data_in       (a_sd),
        .fifo_ready_out       (a_ready),
        .receiver_ready_in    (a_rr),
        .receiver_valid_out   (a_valid),
        .receiver_data_out    (a_data),
        .receiver_last_out    (a_last),
        .fill_count_out       (a_fill),
        .almost_full_out      (a_af),
        .packet_count_out     (a_pkt),
        .packet_available_out (a_pav)
    );

    stream_fifo #(.DEPTH(B_DEPTH), .DATA_WIDTH(16), .ALMOST_FULL_THRESH(4)) dut_b (
        .clk_pixel            (clk),
        .rst_in               (rst),
        .sender_valid_in      (b_sv),
        .sender_last_in       (b_sl),
        .sender_data_in       (b_sd),
        .fifo_ready_out       (b_ready),
        .receiver_ready_in    (b_rr),
        .receiver_valid_out   (b_valid),
        .receiver_data_out    (b_data),
        .receiver_last_out    (b_last),
        .fill_count_out       (b_fill),
        .almost_full_out      (b_af),
        .packet_count_out     (b_pkt),
        .packet_available_out (b_pav)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle on instance A: compare registered state with the model,
    // score any read, update the model, then cross the rising edge.
    task automatic tick();
        logic        wf, rf;
        logic [16:0] ent;
        #1;
        check("a_ready", 32'(a_ready), 32'(!rst && m_cnt < A_DEPTH));
        check("a_valid", 32'(a_valid), 32'(m_cnt != 0));
        check("a_fill",  32'(a_fill),  m_cnt);
        check("a_pkt",   32'(a_pkt),   m_pkt);
        check("a_pav",   32'(a_pav),   32'(m_pkt != 0));
        check("a_afull", 32'(a_af),    32'(m_cnt >= A_AF));
        wf = !rst && a_sv && (m_cnt < A_DEPTH);
        rf = !rst && a_rr && (m_cnt != 0);
        ent = '0;
        if (rf) begin
            if (sb.size() == 0) begin
                check("a_sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                ent = sb.pop_front();
                check("a_rd_data", 32'(a_data), 32'(ent[15:0]));
                check("a_rd_last", 32'(a_last), 32'(ent[16]));
                last_rd = ent[15:0];
                n_pops++;
            end
        end
        if (rst) begin
            m_cnt = 0;
            m_pkt = 0;
            sb.delete();
        end else begin
            if (wf) sb.push_back({a_sl, a_sd});
            m_cnt = m_cnt + int'(wf) - int'(rf);
            m_pkt = m_pkt + int'(wf && a_sl) - int'(rf && ent[16]);
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        sv;
        logic        sl;
        logic [15:0] sd;
        logic        rr;
        logic        ev;
        logic [7:0]  efill;
        logic [7:0]  epkt;
        logic [15:0] ehead;
        logic        ehl;
    } vec_t;

    initial begin
        vec_t vt [10];
        int widx, ridx, bcnt, wwraps, rwraps;
        logic bwf, brf;
        logic [2:0] pw, pr;

        // Empty pass-through, then a simultaneous fire at fill 3.
        vt[0] = '{1'b1, 1'b0, 16'h0005, 1'b0, 1'b1, 8'd1, 8'd0, 16'h0005, 1'b0};
        vt[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'd0, 8'd0, 16'h0000, 1'b0};
        vt[2] = '{1'b1, 1'b1, 16'h0010, 1'b0, 1'b1, 8'd1, 8'd1, 16'h0010, 1'b1};
        vt[3] = '{1'b1, 1'b0, 16'h0011, 1'b0, 1'b1, 8'd2, 8'd1, 16'h0010, 1'b1};
        vt[4] = '{1'b1, 1'b0, 16'h0012, 1'b0, 1'b1, 8'd3, 8'd1, 16'h0010, 1'b1};
        vt[5] = '{1'b1, 1'b1, 16'h0013, 1'b1, 1'b1, 8'd3, 8'd1, 16'h0011, 1'b0};
        vt[6] = '{1'b1, 1'b0, 16'h0014, 1'b1, 1'b1, 8'd3, 8'd1, 16'h0012, 1'b0};
        vt[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'd2, 8'd1, 16'h0013, 1'b1};
        vt[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'd1, 8'd0, 16'h0014, 1'b0};
        vt[9] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'd0, 8'd0, 16'h0000, 1'b0};

        a_sv = 0; a_sl = 0; a_sd = '0; a_rr = 0;
        b_sv = 0; b_sl = 0; b_sd = '0; b_rr = 0;

        // Initial reset and reset values.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_hi", 32'(a_ready), 32'd0);
        check("rst_valid",    32'(a_valid), 32'd0);
        check("rst_fill",     32'(a_fill),  32'd0);
        check("rst_pkt",      32'(a_pkt),   32'd0);
        check("rst_pav",      32'(a_pav),   32'd0);
        check("rst_afull",    32'(a_af),    32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready_lo", 32'(a_ready), 32'd1);

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            a_sv = vt[i].sv; a_sl = vt[i].sl; a_sd = vt[i].sd; a_rr = vt[i].rr;
            tick();
            check("vec_valid", 32'(a_valid), 32'(vt[i].ev));
            check("vec_fill",  32'(a_fill),  32'(vt[i].efill));
            check("vec_pkt",   32'(a_pkt),   32'(vt[i].epkt));
            if (vt[i].ev) begin
                check("vec_head", 32'(a_data), 32'(vt[i].ehead));
                check("vec_hlast", 32'(a_last), 32'(vt[i].ehl));
            end
        end

        // Fill to DEPTH with last on every 16th beat.
        n_pops = 0;
        a_rr = 0;
        for (int i = 0; i < A_DEPTH; i++) begin
            a_sv = 1; a_sd = 16'(i); a_sl = ((i % 16) == 15);
            tick();
            if (i == A_AF - 2) check("afull_below", 32'(a_af), 32'd0);
            if (i == A_AF - 1) check("afull_at",    32'(a_af), 32'd1);
        end
        check("full_fill",  32'(a_fill),  32'd144);
        check("full_pkt",   32'(a_pkt),   32'd9);
        check("full_ready", 32'(a_ready), 32'd0);
        check("full_afull", 32'(a_af),    32'd1);

        // Backpressure at full with 0xAA held on the sender side.
        a_sv = 1; a_sd = 16'h00AA; a_sl = 0;
        repeat (3) tick();
        check("bp_hold_fill", 32'(a_fill), 32'd144);
        a_rr = 1;
        tick();
        check("bp_one_read_fill", 32'(a_fill),  32'd143);
        check("bp_ready_back",    32'(a_ready), 32'd1);
        a_rr = 0;
        tick();
        check("bp_aa_accepted", 32'(a_fill), 32'd144);

        // Drain everything.
        a_sv = 0; a_rr = 1;
        for (int n = 0; n < 200 && m_cnt != 0; n++) tick();
        check("drain_fill",  32'(a_fill),  32'd0);
        check("drain_valid", 32'(a_valid), 32'd0);
        check("drain_pops",  32'(n_pops),  32'd145);
        check("drain_tail",  32'(last_rd), 32'h00AA);
        a_rr = 0;

        // Reset mid-operation at fill 50 with 3 packets.
        for (int i = 0; i < 50; i++) begin
            a_sv = 1; a_sd = 16'(16'h100 + i); a_sl = (i == 9 || i == 19 || i == 29);
            tick();
        end
        a_sv = 0; a_sl = 0;
        check("pre_rst_fill", 32'(a_fill), 32'd50);
        check("pre_rst_pkt",  32'(a_pkt),  32'd3);
        rst = 1; a_sv = 1; a_sd = 16'h0099;
        tick();
        rst = 0; a_sv = 0;
        #1;
        check("mid_rst_fill",  32'(a_fill),  32'd0);
        check("mid_rst_pkt",   32'(a_pkt),   32'd0);
        check("mid_rst_valid", 32'(a_valid), 32'd0);
        check("mid_rst_ready", 32'(a_ready), 32'd1);
        a_sv = 1; a_sd = 16'h0007;
        tick();
        a_sv = 0; a_rr = 1;
        tick();
        check("post_rst_first", 32'(last_rd), 32'h0007);
        a_rr = 0;
        tick();

        // DEPTH=5 continuous stream: order and pointer wrap.
        widx = 0; ridx = 0; bcnt = 0; wwraps = 0; rwraps = 0;
        b_rr = 1;
        for (int c = 0; c < 40 && ridx < 23; c++) begin
            b_sv = (widx < 23); b_sd = 16'(widx);
            #1;
            check("b_ready", 32'(b_ready), 32'(bcnt < B_DEPTH));
            check("b_valid", 32'(b_valid), 32'(bcnt != 0));
            bwf = b_sv && (bcnt < B_DEPTH);
            brf = (bcnt != 0);
            if (brf) begin
                check("b_order", 32'(b_data), ridx);
                ridx++;
            end
            if (bwf) widx++;
            bcnt = bcnt + int'(bwf) - int'(brf);
            pw = dut_b.wr_ptr; pr = dut_b.rd_ptr;
            @(posedge clk);
            #1;
            if (pw == 3'd4 && dut_b.wr_ptr == 3'd0) wwraps++;
            if (pr == 3'd4 && dut_b.rd_ptr == 3'd0) rwraps++;
        end
        b_sv = 0; b_rr = 0;
        check("b_read_total", 32'(ridx), 32'd23);
        check("b_empty",      32'(b_fill), 32'd0);
        check("b_wr_wraps",   32'(wwraps >= 4), 32'd1);
        check("b_rd_wraps",   32'(rwraps >= 4), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
